// File: rtl/future_pkg.sv
// future_pkg: shared definitions for the FUTURE block-cipher round controller.
//   - state_e        : controller FSM state encoding
//   - DP_SEL_*       : state-register datapath mux select encodings
//   - NROUNDS_DEFAULT: default number of cipher rounds
//   - BLOCK_W        : cipher block width in bits (key is two halves of this width)
package future_pkg;

  localparam int unsigned NROUNDS_DEFAULT = 10;
  localparam int unsigned BLOCK_W         = 64;

  // Datapath mux feeding the state register's parallel-load input.
  localparam logic [1:0] DP_SEL_PT  = 2'd0;  // plaintext
  localparam logic [1:0] DP_SEL_SUB = 2'd1;  // SubCell
  localparam logic [1:0] DP_SEL_MIX = 2'd2;  // MixColumn
  localparam logic [1:0] DP_SEL_ARK = 2'd3;  // state XOR round key

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_WHITEN = 3'd2,
    ST_SUB    = 3'd3,
    ST_MIX    = 3'd4,
    ST_SHR    = 3'd5,
    ST_ARK    = 3'd6,
    ST_DONE   = 3'd7
  } state_e;

endpackage

// File: rtl/future_round_cnt.sv
// future_round_cnt: round index counter for the FUTURE controller.
//   clk, rst : clock, synchronous active-high reset (count -> 0)
//   clear    : force count to 0 (has priority over inc)
//   inc      : advance count by one; saturates at NROUNDS
//   cnt      : current round index
//   tc       : terminal count, high while cnt == NROUNDS
module future_round_cnt
  import future_pkg::*;
#(
  parameter int unsigned NROUNDS = NROUNDS_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       inc,
  output logic [3:0] cnt,
  output logic       tc
);

  localparam logic [3:0] TC_VAL = 4'(NROUNDS);

  logic [3:0] cnt_q;
  logic [3:0] cnt_d;

  assign tc  = (cnt_q == TC_VAL);
  assign cnt = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (inc && !tc) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/future_round_ctrl.sv
// future_round_ctrl: sequencing FSM for the FUTURE block cipher datapath.
// Drives the state register (enable / parallel load / ShiftRow), the datapath
// mux and the two key-half registers through whitening plus NROUNDS rounds.
// The final round omits MixColumn. All outputs decode from the state register
// or come from the round counter, so there is no combinational path from start.
// The state register's sh16/sh5 shift inputs are not driven by this controller;
// the enclosing top ties them to 0.
//   clk, rst  : clock, synchronous active-high reset
//   start     : encrypt request, accepted only in IDLE
//   busy      : encryption in progress (accept edge until out_valid rises)
//   out_valid : ciphertext held in the state register, until out_ready
//   out_ready : consumer acknowledge
//   st_en     : state register enable
//   st_load   : state register parallel load of the datapath mux output
//   st_sr     : state register ShiftRow
//   dp_sel    : datapath mux select (DP_SEL_* encodings)
//   key_load  : load both key halves from the key input
//   key_sel   : key half feeding the round-key XOR (0 K0, 1 K1)
//   key_rot   : rotate the selected key half left by 5 after use
//   round     : current round index, 0 during whitening
module future_round_ctrl
  import future_pkg::*;
#(
  parameter int unsigned NROUNDS = NROUNDS_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       busy,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       st_en,
  output logic       st_load,
  output logic       st_sr,
  output logic [1:0] dp_sel,
  output logic       key_load,
  output logic       key_sel,
  output logic       key_rot,
  output logic [3:0] round
);

  state_e state_q;
  state_e state_d;

  logic cnt_clear;
  logic cnt_inc;
  logic cnt_tc;

  // Clearing on the accept edge makes round read 0 through LOAD and WHITEN.
  assign cnt_clear = (state_q == ST_IDLE) && start;
  assign cnt_inc   = (state_q == ST_WHITEN) || ((state_q == ST_ARK) && !cnt_tc);

  future_round_cnt #(
    .NROUNDS (NROUNDS)
  ) u_round_cnt (
    .clk   (clk),
    .rst   (rst),
    .clear (cnt_clear),
    .inc   (cnt_inc),
    .cnt   (round),
    .tc    (cnt_tc)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (start) state_d = ST_LOAD;
      ST_LOAD:   state_d = ST_WHITEN;
      ST_WHITEN: state_d = ST_SUB;
      // tc during SUB marks the final round, which skips MixColumn.
      ST_SUB:    state_d = cnt_tc ? ST_SHR : ST_MIX;
      ST_MIX:    state_d = ST_SHR;
      ST_SHR:    state_d = ST_ARK;
      ST_ARK:    state_d = cnt_tc ? ST_DONE : ST_SUB;
      ST_DONE:   if (out_ready) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    busy      = 1'b0;
    out_valid = 1'b0;
    st_en     = 1'b0;
    st_load   = 1'b0;
    st_sr     = 1'b0;
    dp_sel    = DP_SEL_PT;
    key_load  = 1'b0;
    key_sel   = 1'b0;
    key_rot   = 1'b0;
    unique case (state_q)
      ST_LOAD: begin
        busy     = 1'b1;
        st_en    = 1'b1;
        st_load  = 1'b1;
        dp_sel   = DP_SEL_PT;
        key_load = 1'b1;
      end
      ST_WHITEN: begin
        busy    = 1'b1;
        st_en   = 1'b1;
        st_load = 1'b1;
        dp_sel  = DP_SEL_ARK;
      end
      ST_SUB: begin
        busy    = 1'b1;
        st_en   = 1'b1;
        st_load = 1'b1;
        dp_sel  = DP_SEL_SUB;
      end
      ST_MIX: begin
        busy    = 1'b1;
        st_en   = 1'b1;
        st_load = 1'b1;
        dp_sel  = DP_SEL_MIX;
      end
      ST_SHR: begin
        busy  = 1'b1;
        st_en = 1'b1;
        st_sr = 1'b1;
      end
      ST_ARK: begin
        // Key halves alternate by round parity; the half is rotated on the
        // same edge it is consumed, so the XOR sees the pre-rotation value.
        busy    = 1'b1;
        st_en   = 1'b1;
        st_load = 1'b1;
        dp_sel  = DP_SEL_ARK;
        key_sel = round[0];
        key_rot = 1'b1;
      end
      ST_DONE: begin
        out_valid = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/future_round_ctrl.md
FUTURE_ROUND_CTRL -- requirements
Module: future_round_ctrl

Interface
REQ-001 SHALL have parameter NROUNDS, default 10, number of FUTURE rounds (legal range 2..15).
REQ-002 clk  in  1  rising-edge clock.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 start  in  1  request to encrypt; accepted only in IDLE.
REQ-005 busy  out  1  high from the accepting edge until out_valid rises.
REQ-006 out_valid  out  1  state register holds the ciphertext; held until out_ready.
REQ-007 out_ready  in  1  consumer acknowledge.
REQ-008 st_en  out  1  state register enable.
REQ-009 st_load  out  1  state register parallel load of the datapath mux output.
REQ-010 st_sr  out  1  state register ShiftRow command.
REQ-011 dp_sel  out  2  datapath mux: 0 plaintext, 1 SubCell, 2 MixColumn, 3 state XOR round key.
REQ-012 key_load  out  1  load K0/K1 key-half registers from the key input.
REQ-013 key_sel  out  1  round-key half feeding the XOR: 0 K0, 1 K1.
REQ-014 key_rot  out  1  rotate the selected key half left by 5 (sh5).
REQ-015 round  out  4  current round index, 0 during whitening.

Function
REQ-016 States: IDLE, LOAD, WHITEN, SUB, MIX, SHR, ARK, DONE.
REQ-017 IDLE: start=1 -> LOAD next edge; busy rises on that edge; start while busy or DONE is ignored.
REQ-018 LOAD (1 cycle): st_en=1, st_load=1, dp_sel=0, key_load=1; -> WHITEN, round=0.
REQ-019 WHITEN (1 cycle): st_load=1, dp_sel=3, key_sel=0, key_rot=0; -> SUB, round=1.
REQ-020 SUB: st_load=1, dp_sel=1; -> MIX if round<NROUNDS, else SHR.
REQ-021 MIX: st_load=1, dp_sel=2; -> SHR.
REQ-022 SHR: st_sr=1, st_load=0; -> ARK.
REQ-023 ARK: st_load=1, dp_sel=3, key_sel=round[0], key_rot=1 on the same edge (key updates after use); -> SUB with round+1 if round<NROUNDS, else DONE.
REQ-024 DONE: out_valid=1, busy=0, st_en=0; out_ready=1 -> IDLE next edge; out_valid=1 in the same cycle as out_ready -> out_valid drops next edge.
REQ-025 Exactly one of st_load/st_sr is high whenever st_en=1; st_en=0 in IDLE and DONE; st_en=1 in all other states.
REQ-026 sh16 output absent: the state register's sh16/sh5 inputs are tied 0 at the top level.
REQ-027 Latency: start accept edge to out_valid rising = 2 + 4*(NROUNDS-1) + 3 cycles (41 for NROUNDS=10).
REQ-028 round counter saturates at NROUNDS; wraps to 0 only on LOAD.
REQ-029 Outputs are registered or decoded from state only; no combinational start->output path.

Reset
REQ-030 rst=1 at any edge, including mid-encryption -> IDLE, round=0, all outputs 0; an in-flight encryption is abandoned without out_valid.
REQ-031 rst dominates start and out_ready in the same cycle.

Structure
REQ-032 Shared package future_pkg holds the state enum, DP_SEL_* encodings, NROUNDS_DEFAULT=10 and the 64-bit block width.
REQ-033 Round counter is a sub-module future_round_cnt (clear, inc, terminal-count flag); the FSM is in future_round_ctrl.

Verification
REQ-034 rst, then start pulse -> LOAD next cycle, out_valid exactly 41 cycles after the accepting edge, round sequence 0,1..10.
REQ-035 Top-level with state/key registers, plaintext 0x0000000000000000, key all zero -> ciphertext matches the golden model; key_rot pulses exactly 10 times.
REQ-036 Final round: no MIX cycle (dp_sel never 2 while round=10); MIX cycle present for rounds 1..9.
REQ-037 out_ready held 0 for 20 cycles in DONE -> out_valid and state register stable; start ignored; out_ready=1 -> IDLE next cycle.
REQ-038 rst asserted at round 5 ARK -> all outputs 0 next cycle; fresh start -> full 41-cycle run and correct result.
REQ-039 Assertion over every cycle: st_load and st_sr never both 1; key_rot only in ARK; start in non-IDLE changes nothing.
